serial_cfg_receiver: RTL and testbench

SERIAL_CFG_RECEIVER -- requirements
Module: serial_cfg_receiver

---
 rtl/serial_cfg_receiver.sv | 136 +++++++++++++
 tb/tb_serial_cfg_receiver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_cfg_receiver.sv
// Serial configuration receiver: samples an asynchronous sclk/sel/sdi bridge on CLK and
// accepts MSB-first frames of either the static or the dynamic length.
module serial_cfg_receiver #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  sclk_in,
  input  logic                  sel_in,
  input  logic                  sdi_in,
  output logic [SIZESRSTAT-1:0] STATCNF,
  output logic [SIZESRDYN-1:0]  DYNCNF,
  output logic                  stat_valid,
  output logic                  dyn_valid,
  output logic                  frame_err,
  output logic [7:0]            last_len,
  output logic [7:0]            err_count
);

  localparam int CNT_W = $clog2(SIZESRSTAT + 2);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SIZESRSTAT + 1);
  localparam logic [CNT_W-1:0] CNT_STAT = CNT_W'(SIZESRSTAT);
  localparam logic [CNT_W-1:0] CNT_DYN  = CNT_W'(SIZESRDYN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic [1:0]            sclk_sync, sel_sync, sdi_sync;
  logic                  sclk_d, sel_d, sdi_d;
  logic                  sclk_rise, sel_rise, sel_fall;
  logic [1:0]            flush;
  logic                  armed;
  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [SIZESRSTAT-1:0] shreg;
  logic [7:0]            len_sat;

  // Synchronizers plus one registered edge stage; sdi travels the same path as sclk
  // so sdi_d is the data value seen at the moment sclk_rise was detected.
  // armed blocks a frame start until sel has really been seen low after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync <= '0;
      sel_sync  <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      sel_d     <= 1'b0;
      sdi_d     <= 1'b0;
      sclk_rise <= 1'b0;
      sel_rise  <= 1'b0;
      sel_fall  <= 1'b0;
      flush     <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_in};
      sel_sync  <= {sel_sync[0], sel_in};
      sdi_sync  <= {sdi_sync[0], sdi_in};
      sclk_d    <= sclk_sync[1];
      sel_d     <= sel_sync[1];
      sdi_d     <= sdi_sync[1];
      sclk_rise <= sclk_sync[1] & ~sclk_d;
      sel_rise  <= sel_sync[1] & ~sel_d & armed;
      sel_fall  <= ~sel_sync[1] & sel_d;
      flush     <= {flush[0], 1'b1};
      if (flush[1] && !sel_sync[1]) armed <= 1'b1;
    end
  end

  always_comb begin
    len_sat = 8'(count);
    if (32'(count) > 32'd255) len_sat = 8'hFF;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      count      <= '0;
      shreg      <= '0;
      STATCNF    <= '0;
      DYNCNF     <= '0;
      stat_valid <= 1'b0;
      dyn_valid  <= 1'b0;
      frame_err  <= 1'b0;
      last_len   <= '0;
      err_count  <= '0;
    end else begin
      stat_valid <= 1'b0;
      dyn_valid  <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_rise) begin
            state <= SHIFT;
            count <= '0;
            shreg <= '0;
          end
        end
        SHIFT: begin
          // sel falling wins over an sclk edge detected in the same cycle
          if (sel_fall) begin
            state <= CHECK;
          end else if (sclk_rise && count != CNT_SAT) begin
            shreg <= {shreg[SIZESRSTAT-2:0], sdi_d};
            count <= count + CNT_W'(1);
          end
        end
        CHECK: begin
          if (count == CNT_STAT) begin
            STATCNF    <= shreg;
            stat_valid <= 1'b1;
          end else if (count == CNT_DYN) begin
            DYNCNF    <= shreg[SIZESRDYN-1:0];
            dyn_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
          last_len <= len_sat;
          if (sel_sync[1]) begin
            state <= SHIFT;
            count <= '0;
            shreg <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cfg_receiver.sv
// Bench for serial_cfg_receiver: directed and random frames, expected results queued by a
// frame-level model and checked by a monitor whenever a result pulse appears.
module tb_serial_cfg_receiver;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        sclk_in, sel_in, sdi_in;
  logic [87:0] STATCNF;
  logic [15:0] DYNCNF;
  logic        stat_valid, dyn_valid, frame_err;
  logic [7:0]  last_len, err_count;

  serial_cfg_receiver dut (
    .CLK(CLK), .RST_N(RST_N), .sclk_in(sclk_in), .sel_in(sel_in), .sdi_in(sdi_in),
    .STATCNF(STATCNF), .DYNCNF(DYNCNF), .stat_valid(stat_valid), .dyn_valid(dyn_valid),
    .frame_err(frame_err), .last_len(last_len), .err_count(err_count)
  );

  // clock / reset block
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct packed {
    logic [1:0]  kind;   // 1 static, 2 dynamic, 3 error
    logic [87:0] stat;
    logic [15:0] dyn;
    logic [7:0]  len;
    logic [7:0]  errc;
    logic [31:0] at;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // frame-level reference state
  logic [87:0] m_stat;
  logic [15:0] m_dyn;
  int          m_errc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic model_push(input int n, input logic [127:0] data, input int fall_cyc);
    exp_t e;
    if (n == 88) begin
      m_stat = data[87:0];
      e.kind = 2'd1;
    end else if (n == 16) begin
      m_dyn  = data[15:0];
      e.kind = 2'd2;
    end else begin
      if (m_errc < 255) m_errc++;
      e.kind = 2'd3;
    end
    e.stat = m_stat;
    e.dyn  = m_dyn;
    e.len  = 8'((n > 89) ? 89 : n);
    e.errc = 8'(m_errc);
    e.at   = 32'(fall_cyc + 5);
    exp_q.push_back(e);
  endtask

  // driver: one MSB-first frame, each sclk phase lasting h CLK cycles
  task automatic send_bits(input int first, input int last, input int n,
                           input logic [127:0] data, input int h);
    for (int i = first; i < last; i++) begin
      sdi_in = data[n-1-i];
      step(h);
      sclk_in = 1'b1;
      step(h);
      sclk_in = 1'b0;
    end
  endtask

  task automatic send_frame(input int n, input logic [127:0] data, input int h);
    sel_in  = 1'b1;
    sclk_in = 1'b0;
    step(h);
    send_bits(0, n, n, data, h);
    step(h);
    sel_in = 1'b0;
    model_push(n, data, cyc);
    step(12);
    chk("result_arrived", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (RST_N && (stat_valid || dyn_valid || frame_err)) begin
      chk("one_hot", 128'(int'(stat_valid) + int'(dyn_valid) + int'(frame_err)), 128'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=%b%b%b required=000 cyc=%0d",
                 stat_valid, dyn_valid, frame_err, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("kind", 128'(stat_valid ? 2'd1 : dyn_valid ? 2'd2 : 2'd3), 128'(e.kind));
        chk("statcnf", 128'(STATCNF), 128'(e.stat));
        chk("dyncnf", 128'(DYNCNF), 128'(e.dyn));
        chk("last_len", 128'(last_len), 128'(e.len));
        chk("err_count", 128'(err_count), 128'(e.errc));
        chk("latency", 128'(cyc), 128'(e.at));
      end
    end
  end

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [127:0] d;
    int n, h;
    RST_N = 1'b0; sclk_in = 1'b0; sel_in = 1'b0; sdi_in = 1'b0;
    m_stat = '0; m_dyn = '0; m_errc = 0;
    step(3);
    chk("rst_statcnf", 128'(STATCNF), 128'd0);
    chk("rst_dyncnf", 128'(DYNCNF), 128'd0);
    chk("rst_pulses", 128'({stat_valid, dyn_valid, frame_err}), 128'd0);
    chk("rst_last_len", 128'(last_len), 128'd0);
    chk("rst_err_count", 128'(err_count), 128'd0);
    RST_N = 1'b1;
    step(6);

    // directed frames
    send_frame(88, 128'h0000_0000_00FE_DCBA_9876_5432_1001_2345, 4);
    send_frame(16, 128'h4321, 4);
    send_frame(16, 128'hABCD, 8);
    d = {$urandom, $urandom, $urandom, $urandom};
    send_frame(17, d, 4);
    d = {$urandom, $urandom, $urandom, $urandom};
    send_frame(100, d, 3);

    // random frames
    for (int k = 0; k < 16; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      h = $urandom_range(3, 8);
      case ($urandom_range(0, 3))
        0:       n = 88;
        1:       n = 16;
        2:       n = $urandom_range(0, 100);
        default: n = ($urandom_range(0, 1) != 0) ? 16 : 15;
      endcase
      send_frame(n, d, h);
    end

    // zero-bit frames drive the error counter into saturation
    for (int k = 0; k < 256; k++) begin
      sel_in = 1'b1;
      step(6);
      sel_in = 1'b0;
      model_push(0, '0, cyc);
      step(12);
      chk("zero_frame_arrived", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
    chk("err_sat", 128'(err_count), 128'd255);

    // reset in the middle of a static frame, released with sel still high
    d = 128'h0000_0000_00FE_DCBA_9876_5432_1001_2345;
    sel_in = 1'b1;
    step(4);
    send_bits(0, 40, 88, d, 4);
    RST_N = 1'b0;
    #1;
    chk("midrst_statcnf", 128'(STATCNF), 128'd0);
    chk("midrst_dyncnf", 128'(DYNCNF), 128'd0);
    chk("midrst_last_len", 128'(last_len), 128'd0);
    chk("midrst_err_count", 128'(err_count), 128'd0);
    m_stat = '0; m_dyn = '0; m_errc = 0;
    step(3);
    RST_N = 1'b1;
    step(3);
    send_bits(40, 88, 88, d, 4);
    step(4);
    sel_in = 1'b0;
    step(14);
    chk("midrst_no_pulse_err", 128'(err_count), 128'd0);
    chk("midrst_no_pulse_len", 128'(last_len), 128'd0);
    send_frame(16, 128'h5A3C, 4);
    chk("final_statcnf", 128'(STATCNF), 128'(m_stat));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
